// File: rtl/uno_pkg.sv
// Shared types and constants for the uno sequencer: op and state encodings,
// the polynomial order limit and the coefficient word type. The datapath
// width defaults to 12 bits unless MAC_BW is defined ahead of this file.
`ifndef MAC_BW
`define MAC_BW 12
`endif

package uno_pkg;

  typedef enum logic [1:0] {
    OP_MAC = 2'b00,
    OP_DIV = 2'b01,
    OP_EXP = 2'b10,
    OP_LOG = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Coefficient table depth; the ROM holds exactly this many entries per op.
  localparam int MAX_ORDER = 8;

  typedef logic [`MAC_BW-1:0] coeff_t;

  // ROM master word: signed Q5.10, rescaled to the datapath width on output.
  typedef logic signed [15:0] rom_word_t;

endpackage

// File: rtl/uno_coeff_rom.sv
// Combinational Taylor coefficient table, indexed by op and term index.
//   div : 1/x   around 0.75 -> c_n = (-1)^n (4/3)^(n+1)
//   exp : e^x   around 0    -> c_n = 1/n!
//   log : ln(x) around 0.75 -> c_0 = ln(0.75), c_n = (-1)^(n+1) (4/3)^n / n
// Master values are Q5.10; the output keeps the top MAC_BW bits
// (arithmetic right shift) or zero-extends at the bottom for MAC_BW > 16.
// The MAC op has no coefficients and reads as 0.
module uno_coeff_rom #(
  parameter int MAC_BW = `MAC_BW
) (
  input  logic [1:0]        op,
  input  logic [2:0]        idx,
  output logic [MAC_BW-1:0] coeff
);
  import uno_pkg::*;

  localparam rom_word_t DIV_TAB [8] = '{
     16'sd1365, -16'sd1820,  16'sd2427, -16'sd3236,
     16'sd4315, -16'sd5754,  16'sd7671, -16'sd10228
  };
  localparam rom_word_t EXP_TAB [8] = '{
     16'sd1024,  16'sd1024,  16'sd512,   16'sd171,
     16'sd43,    16'sd9,     16'sd1,     16'sd0
  };
  localparam rom_word_t LOG_TAB [8] = '{
    -16'sd295,   16'sd1365, -16'sd910,   16'sd809,
    -16'sd809,   16'sd863,  -16'sd959,   16'sd1096
  };

  rom_word_t word;

  // Select the master word for the requested op and term.
  always_comb begin
    word = '0;
    case (op_e'(op))
      OP_DIV:  word = DIV_TAB[idx];
      OP_EXP:  word = EXP_TAB[idx];
      OP_LOG:  word = LOG_TAB[idx];
      default: word = '0;
    endcase
  end

  generate
    if (MAC_BW <= 16) begin : g_narrow
      assign coeff = MAC_BW'(word >>> (16 - MAC_BW));
    end else begin : g_wide
      assign coeff = {word, {(MAC_BW - 16){1'b0}}};
    end
  endgenerate

endmodule

// File: rtl/uno_seq.sv
// Step sequencer for the uno MAC datapath. Accepts one request at a time
// (MAC of L beats, or an order-N polynomial for div/exp/log), walks the step
// counter through RUN, spends one DRAIN cycle covering the registered MAC
// latency, and pulses res_valid in DONE.
// Build option: UNO_SEQ_LEN_CHK_EN rejects zero-length MAC requests and
// polynomial orders below 2 with a one-cycle err pulse instead of padding them.
// The coefficient ROM holds 8 terms, so MAX_ORDER must not exceed 8.
module uno_seq #(
  parameter int MAC_BW    = `MAC_BW,
  parameter int MAX_ORDER = uno_pkg::MAX_ORDER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [7:0]        req_len,
  output logic [1:0]        op,
  output logic              first_cycle,
  output logic              last_cycle,
  output logic              acc_en,
  output logic [MAC_BW-1:0] coeff,
  output logic              res_valid,
  output logic              busy,
  output logic              err
);
  import uno_pkg::*;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [7:0] ORDER_MAX = 8'(MAX_ORDER);

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        k_q, k_d;
  logic              err_q, err_d;

  logic              accept;
  logic              len_bad;
  logic [7:0]        eff_len;
  logic              in_run;
  logic              poly_op;
  logic              is_last;
  logic [2:0]        rom_idx;
  logic [MAC_BW-1:0] rom_coeff;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Length actually run: pad short requests, clamp polynomial order.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eff_len = req_len;
    if (req_op == OP_MAC) begin
      if (req_len == 8'd0) eff_len = 8'd1;
    end else begin
      if (req_len < 8'd2)          eff_len = 8'd2;
      else if (req_len > ORDER_MAX) eff_len = ORDER_MAX;
    end
  end

`ifdef UNO_SEQ_LEN_CHK_EN
  assign len_bad = (req_len == 8'd0) || ((req_op != OP_MAC) && (req_len == 8'd1));
`else
  assign len_bad = 1'b0;
`endif

  // Next-state logic: accept, step through RUN, drain, report.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    k_d     = k_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_RUN;
            op_d    = req_op;
            len_d   = eff_len;
            k_d     = 8'd0;
          end
        end
      end
      S_RUN: begin
        // k stops at the last step, so it never wraps even for L = 255.
        if (is_last) state_d = S_DRAIN;
        else         k_d     = k_q + 8'd1;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      len_q   <= 8'd0;
      k_q     <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  assign in_run  = (state_q == S_RUN);
  assign poly_op = (op_q != OP_MAC);
  assign is_last = (k_q == len_q - 8'd1);

  // Horner order: highest term first, so index counts down from N-1.
  assign rom_idx = 3'(len_q - 8'd1 - k_q);

  uno_coeff_rom #(
    .MAC_BW (MAC_BW)
  ) u_coeff_rom (
    .op    (op_q),
    .idx   (rom_idx),
    .coeff (rom_coeff)
  );

  assign op          = op_q;
  assign first_cycle = in_run && (k_q == 8'd0);
  assign last_cycle  = in_run && is_last;
  assign acc_en      = in_run && !poly_op && (k_q != 8'd0);
  assign coeff       = (in_run && poly_op && !is_last) ? rom_coeff : '0;
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq: MAC, exp, clamped log, back-to-back requests,
// mid-operation reset and short-length handling (both build options).
// Expected values are hand-derived; coefficients assume MAC_BW = 12.
module tb_uno_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_len;
  logic [1:0]  op;
  logic        first_cycle;
  logic        last_cycle;
  logic        acc_en;
  logic [11:0] coeff;
  logic        res_valid;
  logic        busy;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {busy, res_valid, first_cycle, last_cycle, acc_en}
  logic [4:0] flags;
  assign flags = {busy, res_valid, first_cycle, last_cycle, acc_en};

  uno_seq dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_len     (req_len),
    .op          (op),
    .first_cycle (first_cycle),
    .last_cycle  (last_cycle),
    .acc_en      (acc_en),
    .coeff       (coeff),
    .res_valid   (res_valid),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE; returns in cycle 1 after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [7:0] l);
    req_valid = 1'b1;
    req_op    = o;
    req_len   = l;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_len = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    total_cnt++;
    if ({req_ready, busy, res_valid, err, first_cycle, last_cycle, acc_en, op, coeff} !== {4'b1000, 3'b000, 2'b00, 12'h000})
      $display("FAIL reset_outputs: got rdy=%b busy=%b rv=%b err=%b flags=%b op=%b coeff=%h, want rdy=1 rest 0",
               req_ready, busy, res_valid, err, {first_cycle, last_cycle, acc_en}, op, coeff);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({req_ready, busy} !== 2'b10)
      $display("FAIL reset_release: got rdy=%b busy=%b want rdy=1 busy=0", req_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_mac4();
    logic [4:0] tab [7];
    tab = '{5'b10100, 5'b10001, 5'b10001, 5'b10011, 5'b10000, 5'b11000, 5'b00000};
    issue(2'b00, 8'd4);
    for (int c = 1; c <= 7; c++) begin
      total_cnt++;
      if (flags !== tab[c-1] || coeff !== 12'h000 || op !== 2'b00)
        $display("FAIL mac4 c%0d: got flags=%b coeff=%h op=%b want flags=%b coeff=000 op=00",
                 c, flags, coeff, op, tab[c-1]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_exp4();
    logic [4:0]  tab [7];
    logic [11:0] ctab [7];
    tab  = '{5'b10100, 5'b10000, 5'b10000, 5'b10010, 5'b10000, 5'b11000, 5'b00000};
    ctab = '{12'd10, 12'd32, 12'd64, 12'd0, 12'd0, 12'd0, 12'd0};
    issue(2'b10, 8'd4);
    for (int c = 1; c <= 7; c++) begin
      total_cnt++;
      if (flags !== tab[c-1] || coeff !== ctab[c-1] || op !== 2'b10)
        $display("FAIL exp4 c%0d: got flags=%b coeff=%h op=%b want flags=%b coeff=%h op=10",
                 c, flags, coeff, op, tab[c-1], ctab[c-1]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_log_clamp();
    logic [4:0] want;
    issue(2'b11, 8'd12);
    for (int c = 1; c <= 11; c++) begin
      want = {(c <= 10), (c == 10), (c == 1), (c == 8), 1'b0};
      total_cnt++;
      if (flags !== want)
        $display("FAIL log_clamp_flags c%0d: got %b want %b", c, flags, want);
      else pass_cnt++;
      if (c == 1) begin
        total_cnt++;
        if (coeff !== 12'd68) $display("FAIL log_coeff7: got %h want %h", coeff, 12'd68);
        else pass_cnt++;
      end
      if (c == 2) begin
        total_cnt++;
        if (coeff !== 12'hFC4) $display("FAIL log_coeff6: got %h want FC4", coeff);
        else pass_cnt++;
      end
      if (c == 8) begin
        total_cnt++;
        if (coeff !== 12'h000) $display("FAIL log_coeff_last: got %h want 000", coeff);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // {req_ready, busy, res_valid, first_cycle}
    logic [3:0] tab [6];
    tab = '{4'b0101, 4'b0100, 4'b0100, 4'b0110, 4'b1000, 4'b0101};
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_len   = 8'd2;
    tick();
    for (int c = 1; c <= 6; c++) begin
      total_cnt++;
      if ({req_ready, busy, res_valid, first_cycle} !== tab[c-1])
        $display("FAIL b2b c%0d: got rdy/busy/rv/first=%b want %b",
                 c, {req_ready, busy, res_valid, first_cycle}, tab[c-1]);
      else pass_cnt++;
      if (c == 6) req_valid = 1'b0;
      tick();
    end
    wait_idle("b2b");
    tick();
  endtask

  task automatic test_rst_mid();
    int rv_seen = 0;
    issue(2'b10, 8'd6);
    tick();
    tick();
    total_cnt++;
    if ({busy, first_cycle} !== 2'b10)
      $display("FAIL rst_mid_pre: got busy=%b first=%b want busy=1 first=0", busy, first_cycle);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({req_ready, busy, res_valid, err, first_cycle, last_cycle, acc_en, op, coeff} !== {4'b1000, 3'b000, 2'b00, 12'h000})
      $display("FAIL rst_mid_outputs: got rdy=%b busy=%b rv=%b err=%b flags=%b op=%b coeff=%h, want rdy=1 rest 0",
               req_ready, busy, res_valid, err, {first_cycle, last_cycle, acc_en}, op, coeff);
    else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      if (res_valid === 1'b1 || busy === 1'b1) rv_seen++;
      tick();
    end
    total_cnt++;
    if (rv_seen != 0) $display("FAIL rst_mid_no_result: got %0d active cycles want 0", rv_seen);
    else pass_cnt++;
  endtask

  task automatic test_short_len();
`ifdef UNO_SEQ_LEN_CHK_EN
    for (int t = 0; t < 2; t++) begin
      if (t == 0) issue(2'b00, 8'd0);
      else        issue(2'b01, 8'd1);
      total_cnt++;
      if ({err, busy, req_ready, first_cycle} !== 4'b1010)
        $display("FAIL short_len_reject%0d: got err/busy/rdy/first=%b want 1010",
                 t, {err, busy, req_ready, first_cycle});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({err, busy} !== 2'b00)
        $display("FAIL short_len_after%0d: got err=%b busy=%b want 0 0", t, err, busy);
      else pass_cnt++;
      tick();
    end
`else
    logic [4:0]  tab [5];
    logic [11:0] ctab [5];
    tab = '{5'b10110, 5'b10000, 5'b11000, 5'b00000, 5'b00000};
    issue(2'b00, 8'd0);
    for (int c = 1; c <= 4; c++) begin
      total_cnt++;
      if (flags !== tab[c-1] || err !== 1'b0)
        $display("FAIL mac_len0 c%0d: got flags=%b err=%b want flags=%b err=0", c, flags, err, tab[c-1]);
      else pass_cnt++;
      tick();
    end
    tab  = '{5'b10100, 5'b10010, 5'b10000, 5'b11000, 5'b00000};
    ctab = '{12'hF8E, 12'h000, 12'h000, 12'h000, 12'h000};
    issue(2'b01, 8'd1);
    for (int c = 1; c <= 5; c++) begin
      total_cnt++;
      if (flags !== tab[c-1] || coeff !== ctab[c-1])
        $display("FAIL div_len1 c%0d: got flags=%b coeff=%h want flags=%b coeff=%h",
                 c, flags, coeff, tab[c-1], ctab[c-1]);
      else pass_cnt++;
      tick();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mac4();
    test_exp4();
    test_log_clamp();
    test_back_to_back();
    test_rst_mid();
    test_short_len();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
